// File: rtl/mem_port_requester.sv
// rtl/mem_port_requester.sv - single-port RAM initiator with credit-limited in-order read responses
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_ready      client request stream; req_we selects write (1) or read (0),
//   req_we/req_addr/req_wdata  req_addr/req_wdata carry the address and write data
//   rsp_valid/rsp_ready      read response stream, data on rsp_rdata, strictly in request order
//   mem_wren/mem_rden        registered RAM port controls (never both high)
//   mem_addr/mem_wdata       registered RAM address and write data
//   mem_rdata                RAM read data, valid the cycle after mem_rden
//   idle                     no read in the RAM pipeline and the response FIFO is empty
module mem_port_requester #(
    parameter int ABITS     = 12,
    parameter int WIDTH     = 72,
    parameter int RSP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ABITS-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             mem_wren,
    output logic             mem_rden,
    output logic [ABITS-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             idle
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    // Counter must hold occupancy plus up to two reads still in the RAM pipeline.
    localparam int CW = $clog2(RSP_DEPTH + 3);

    logic             rden_d;
    logic [WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    occ;
    logic [CW-1:0]    occ_nxt;
    logic [CW-1:0]    used;
    logic             accept;
    logic             push;
    logic             pop;
    logic             credit_ok;

    // Pointers wrap at RSP_DEPTH so non power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(RSP_DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign pop        = rsp_valid & rsp_ready;
    assign push       = rden_d;
    assign rd_ptr_nxt = ptr_inc(rd_ptr);
    assign occ_nxt    = occ + CW'(push) - CW'(pop);

    // Every issued read already owns a FIFO slot; the entry leaving this cycle is
    // counted as free so one read per cycle can be sustained with 3+ entries.
    assign used      = occ + CW'(mem_rden) + CW'(rden_d) - CW'(pop);
    assign credit_ok = used < CW'(RSP_DEPTH);

    // Writes produce no response, so they bypass the credit check.
    assign req_ready = ~rst & (req_we | credit_ok);
    assign accept    = req_valid & req_ready;

    assign idle = ~mem_rden & ~rden_d & (occ == '0);

    // Issue stage and RAM-latency tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wren  <= 1'b0;
            mem_rden  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rden_d    <= 1'b0;
        end else begin
            mem_wren <= accept & req_we;
            mem_rden <= accept & ~req_we;
            rden_d   <= mem_rden;
            if (accept) begin
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end
        end
    end

    // FIFO storage holds no control state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    // FIFO control with a registered head: rsp_rdata is reloaded from the next
    // entry on pop, or straight from mem_rdata when that entry is arriving now.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            occ       <= occ_nxt;
            rsp_valid <= (occ_nxt != '0);
            if (pop && (occ != CW'(1))) begin
                rsp_rdata <= fifo_mem[rd_ptr_nxt];
            end else if (push && ((occ == '0) || pop)) begin
                rsp_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (occ == CW'(RSP_DEPTH))));
        end
    end

endmodule

// File: tb/tb_mem_port_requester.sv
// tb/tb_mem_port_requester.sv - self-checking bench for mem_port_requester
module tb_mem_port_requester;

    localparam int ABITS = 12;
    localparam int WIDTH = 72;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_we = 1'b0;
    logic [ABITS-1:0] req_addr = '0;
    logic [WIDTH-1:0] req_wdata = '0;
    logic             rsp_ready = 1'b0;
    logic             req_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             mem_wren;
    logic             mem_rden;
    logic [ABITS-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata = '0;
    logic             idle;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_port_requester #(.ABITS(ABITS), .WIDTH(WIDTH), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .idle(idle)
    );

    function automatic logic [WIDTH-1:0] rnd72();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[WIDTH-1:0];
    endfunction

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // RAM with 1-cycle read latency; output is scrambled when not reading.
    logic [WIDTH-1:0] ram [2**ABITS];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        if (mem_rden) mem_rdata <= ram[mem_addr];
        else          mem_rdata <= rnd72();
    end

    // Transaction-level reference: shadow memory updated at accept, reads queue
    // the shadow value expected back in order.
    logic [WIDTH-1:0] shadow [2**ABITS];
    logic [WIDTH-1:0] exp_q [$];
    int               rsp_cyc_q [$];
    int               rsp_cnt = 0;
    int               acc_cnt = 0;
    int               wren_cnt = 0;
    int               last_acc_cyc = 0;
    int               last_rsp_cyc = 0;
    logic [WIDTH-1:0] last_rsp_data = '0;
    bit               p_acc = 0;
    bit               p_we = 0;
    bit               p_stall = 0;
    logic [ABITS-1:0] p_addr = '0;
    logic [WIDTH-1:0] p_wdata = '0;
    logic [WIDTH-1:0] p_data = '0;
    bit               m_acc;
    bit               m_pop;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("ready_in_rst", WIDTH'(req_ready), '0);
            exp_q.delete();
            p_acc = 0; p_addr = '0; p_wdata = '0; p_stall = 0;
        end else begin
            m_acc = req_valid & req_ready;
            m_pop = rsp_valid & rsp_ready;
            chk("mem_wren", WIDTH'(mem_wren), WIDTH'(p_acc & p_we));
            chk("mem_rden", WIDTH'(mem_rden), WIDTH'(p_acc & ~p_we));
            chk("mem_addr", WIDTH'(mem_addr), WIDTH'(p_addr));
            chk("mem_wdata", mem_wdata, p_wdata);
            if (mem_wren) wren_cnt++;
            chk("idle", WIDTH'(idle), WIDTH'(exp_q.size() == 0));
            chk("req_ready", WIDTH'(req_ready),
                WIDTH'(req_we || ((exp_q.size() - int'(m_pop)) < DEPTH)));
            chk("rsp_spurious", WIDTH'(rsp_valid && exp_q.size() == 0), '0);
            if (p_stall) begin
                chk("rsp_hold_valid", WIDTH'(rsp_valid), WIDTH'(1));
                chk("rsp_hold_data", rsp_rdata, p_data);
            end
            if (m_pop && exp_q.size() != 0) begin
                chk("rsp_data", rsp_rdata, exp_q.pop_front());
                rsp_cnt++;
                last_rsp_cyc = cyc;
                last_rsp_data = rsp_rdata;
                rsp_cyc_q.push_back(cyc);
            end
            if (m_acc) begin
                acc_cnt++;
                last_acc_cyc = cyc;
                if (req_we) shadow[req_addr] = req_wdata;
                else        exp_q.push_back(shadow[req_addr]);
            end
            p_acc = m_acc;
            p_we = req_we;
            if (m_acc) begin
                p_addr = req_addr;
                p_wdata = req_wdata;
            end
            p_stall = rsp_valid & ~rsp_ready;
            p_data = rsp_rdata;
        end
    end

    // Called right after a posedge; returns right after the accepting posedge.
    task automatic issue(input bit we, input logic [ABITS-1:0] a, input logic [WIDTH-1:0] d,
                         output int waited);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        waited = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
        end
        checks++;
        if (waited >= 100) begin
            errors++;
            $display("FAIL issue_timeout: waited %0d cycles, expected under 100", waited);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_cnt < target && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (rsp_cnt < target) begin
            errors++;
            $display("FAIL wait_rsp: got %0d responses, expected %0d", rsp_cnt, target);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit               we;
        logic [ABITS-1:0] addr;
        logic [WIDTH-1:0] wdata;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int wsum;
        int base;
        int k;
        int w0;
        logic [WIDTH-1:0] d0;

        for (int i = 0; i < 2**ABITS; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        tbl[0] = '{1'b1, 12'd3,    72'hA5, '0};
        tbl[1] = '{1'b0, 12'd3,    '0, 72'hA5};
        tbl[2] = '{1'b1, 12'd7,    72'h1, '0};
        tbl[3] = '{1'b0, 12'd7,    '0, 72'h1};
        tbl[4] = '{1'b1, 12'hFFF,  72'hFF_FFFF_FFFF_FFFF_FFFF, '0};
        tbl[5] = '{1'b0, 12'hFFF,  '0, 72'hFF_FFFF_FFFF_FFFF_FFFF};
        tbl[6] = '{1'b1, 12'h000,  72'h80_0000_0000_0000_0001, '0};
        tbl[7] = '{1'b0, 12'h000,  '0, 72'h80_0000_0000_0000_0001};

        // Reset and reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", WIDTH'(rsp_valid), '0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_idle", WIDTH'(idle), WIDTH'(1));
        chk("rst_mem_wren", WIDTH'(mem_wren), '0);
        chk("rst_mem_rden", WIDTH'(mem_rden), '0);
        chk("rst_mem_addr", WIDTH'(mem_addr), '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_req_ready", WIDTH'(req_ready), WIDTH'(1));
        @(posedge clk); #1;

        // Directed vectors: write then read back next cycle, latency exactly 3.
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            base = rsp_cnt;
            issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, w);
            chk("tbl_wait", WIDTH'(w), '0);
            if (!tbl[i].we) begin
                req_valid = 1'b0;
                wait_rsp(base + 1);
                chk("tbl_rdata", last_rsp_data, tbl[i].exp);
                chk("tbl_latency", WIDTH'(last_rsp_cyc - last_acc_cyc), WIDTH'(3));
            end
        end

        // 16 back-to-back reads: never stalled, responses on consecutive cycles.
        for (int i = 0; i < 16; i++) issue(1'b1, ABITS'(i), rnd72(), w);
        base = rsp_cnt;
        wsum = 0;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, ABITS'(i), '0, w);
            wsum += w;
        end
        req_valid = 1'b0;
        chk("b2b_stalls", WIDTH'(wsum), '0);
        wait_rsp(base + 16);
        for (int i = rsp_cyc_q.size() - 15; i < rsp_cyc_q.size(); i++)
            chk("b2b_gap", WIDTH'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), WIDTH'(1));

        // Backpressure: only DEPTH reads accepted.
        rsp_ready = 1'b0;
        base = rsp_cnt;
        k = 0;
        req_valid = 1'b1;
        req_we = 1'b0;
        for (int c = 0; c < 12; c++) begin
            req_addr = ABITS'(k);
            @(negedge clk);
            if (req_ready) k++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", WIDTH'(k), WIDTH'(DEPTH));
        @(negedge clk);
        chk("bp_ready_low", WIDTH'(req_ready), '0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        d0 = rsp_rdata;

        // Writes pass while the FIFO is full.
        w0 = wren_cnt;
        wsum = 0;
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, ABITS'(100 + i), rnd72(), w);
            wsum += w;
        end
        req_valid = 1'b0;
        @(negedge clk); #1;
        chk("full_wr_stalls", WIDTH'(wsum), '0);
        chk("full_wren_pulses", WIDTH'(wren_cnt - w0), WIDTH'(5));
        chk("full_rsp_valid", WIDTH'(rsp_valid), WIDTH'(1));
        chk("full_rsp_rdata", rsp_rdata, d0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = k; i < 8; i++) issue(1'b0, ABITS'(i), '0, w);
        req_valid = 1'b0;
        wait_rsp(base + 8);

        // Alternating read/write against the model.
        for (int i = 0; i < 20; i++)
            issue(i[0] == 1'b0, ABITS'($urandom_range(0, 7)), rnd72(), w);
        drain();

        // Random traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1) == 1;
            req_addr  = ABITS'($urandom_range(0, 15));
            req_wdata = rnd72();
            rsp_ready = (c % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        drain();

        // Reset with reads in flight and a partly full FIFO.
        rsp_ready = 1'b0;
        issue(1'b0, 12'd1, '0, w);
        issue(1'b0, 12'd2, '0, w);
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        issue(1'b0, 12'd3, '0, w);
        issue(1'b0, 12'd4, '0, w);
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rden", WIDTH'(mem_rden), WIDTH'(1));
        chk("mid_idle", WIDTH'(idle), '0);
        chk("mid_rsp_valid", WIDTH'(rsp_valid), WIDTH'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp_valid", WIDTH'(rsp_valid), '0);
        chk("post_rst_idle", WIDTH'(idle), WIDTH'(1));
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        base = rsp_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_no_rsp", WIDTH'(rsp_cnt - base), '0);
        issue(1'b0, 12'd5, '0, w);
        req_valid = 1'b0;
        wait_rsp(base + 1);
        chk("post_rst_latency", WIDTH'(last_rsp_cyc - last_acc_cyc), WIDTH'(3));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
